// File: rtl/decrypt_pkg.sv
// rtl/decrypt_pkg.sv - shared width, slot type and token decode function for the exit-side decoder
// Optional build macro: DECRYPT_ROTATE_EN (adds rotate-right by one after the XOR)
package decrypt_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef logic [DEFAULT_WIDTH-1:0] park_num_t;

  function automatic park_num_t decode_park(input park_num_t token, input park_num_t pattern);
    park_num_t x;
    x = token ^ pattern;
`ifdef DECRYPT_ROTATE_EN
    return {x[0], x[DEFAULT_WIDTH-1:1]};
`else
    return x;
`endif
  endfunction

endpackage

// File: rtl/decrypt_core.sv
// rtl/decrypt_core.sv - combinational token decode (XOR with pattern, optional rotate)
// Optional build macro: DECRYPT_ROTATE_EN
module decrypt_core
  import decrypt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] token,
  input  logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] plain
);

  generate
    if (WIDTH == DEFAULT_WIDTH) begin : g_pkg
      // Default width shares the package definition with the encrypt side.
      assign plain = decode_park(token, pattern);
    end else begin : g_generic
      logic [WIDTH-1:0] x;
      assign x = token ^ pattern;
`ifdef DECRYPT_ROTATE_EN
      assign plain = {x[0], x[WIDTH-1:1]};
`else
      assign plain = x;
`endif
    end
  endgenerate

endmodule

// File: rtl/decrypt.sv
// rtl/decrypt.sv - exit token decoder: one registered decode per cycle, outputs zeroed when idle
// Optional build macro: DECRYPT_ROTATE_EN (selects rotate-after-XOR decode in decrypt_core)
module decrypt
  import decrypt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exit,
  input  logic [WIDTH-1:0] token,
  input  logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] park_number,
  output logic             park_valid
);

  logic [WIDTH-1:0] plain;

  decrypt_core #(.WIDTH(WIDTH)) u_core (
    .token   (token),
    .pattern (pattern),
    .plain   (plain)
  );

  // Idle cycles clear the slot number so a stale value is never visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      park_number <= '0;
      park_valid  <= 1'b0;
    end else if (exit) begin
      park_number <= plain;
      park_valid  <= 1'b1;
    end else begin
      park_number <= '0;
      park_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decrypt.sv
// tb/tb_decrypt.sv - scoreboard bench for decrypt (expectations switch with DECRYPT_ROTATE_EN)
module tb_decrypt;

  logic       clk;
  logic       rst_n;
  logic       exit;
  logic [2:0] token;
  logic [2:0] pattern;
  logic [2:0] park_number;
  logic       park_valid;

  typedef struct packed {
    logic       valid;
    logic [2:0] num;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  decrypt #(.WIDTH(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exit        (exit),
    .token       (token),
    .pattern     (pattern),
    .park_number (park_number),
    .park_valid  (park_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed results for pattern 010, tokens 000..111.
`ifdef DECRYPT_ROTATE_EN
  logic [2:0] sweep_exp [8] = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b011, 3'b111, 3'b010, 3'b110};
  localparam logic [2:0] EXP_111_010 = 3'b110;
  localparam logic [2:0] EXP_101_101 = 3'b000;
  localparam logic [2:0] EXP_000_111 = 3'b111;
  localparam logic [2:0] EXP_001_100 = 3'b110;
`else
  logic [2:0] sweep_exp [8] = '{3'b010, 3'b011, 3'b000, 3'b001, 3'b110, 3'b111, 3'b100, 3'b101};
  localparam logic [2:0] EXP_111_010 = 3'b101;
  localparam logic [2:0] EXP_101_101 = 3'b000;
  localparam logic [2:0] EXP_000_111 = 3'b111;
  localparam logic [2:0] EXP_001_100 = 3'b101;
`endif

  task automatic drive(input logic r, input logic e, input logic [2:0] t,
                       input logic [2:0] p, input logic ev, input logic [2:0] en);
    exp_t x;
    @(negedge clk);
    rst_n   = r;
    exit    = e;
    token   = t;
    pattern = p;
    x.valid = ev;
    x.num   = en;
    exp_q.push_back(x);
  endtask

  // Monitor: one expected entry per clock, compared just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (park_valid !== x.valid) begin
          errors++;
          $display("FAIL park_valid got %b want %b", park_valid, x.valid);
        end
        checks++;
        if (park_number !== x.num) begin
          errors++;
          $display("FAIL park_number got %b want %b", park_number, x.num);
        end
      end
    end
  end

  initial begin
    int budget;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    exit    = 1'b0;
    token   = 3'b000;
    pattern = 3'b010;

    // reset overrides a pending request
    drive(1'b0, 1'b1, 3'b101, 3'b010, 1'b0, 3'b000);
    drive(1'b0, 1'b1, 3'b101, 3'b010, 1'b0, 3'b000);
    // idle cycle
    drive(1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 3'b000);
    // back-to-back sweep
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b1, 3'(i), 3'b010, 1'b1, sweep_exp[i]);
    // drop exit: outputs forced to zero
    drive(1'b1, 1'b0, 3'b111, 3'b010, 1'b0, 3'b000);
    // request discarded by reset in the same cycle, then decoded after release
    drive(1'b1, 1'b1, 3'b111, 3'b010, 1'b1, EXP_111_010);
    drive(1'b0, 1'b1, 3'b111, 3'b010, 1'b0, 3'b000);
    drive(1'b1, 1'b1, 3'b111, 3'b010, 1'b1, EXP_111_010);
    // pattern changes take effect on the next request
    drive(1'b1, 1'b1, 3'b101, 3'b101, 1'b1, EXP_101_101);
    drive(1'b1, 1'b1, 3'b000, 3'b111, 1'b1, EXP_000_111);
    drive(1'b1, 1'b1, 3'b001, 3'b100, 1'b1, EXP_001_100);
    drive(1'b1, 1'b0, 3'b001, 3'b100, 1'b0, 3'b000);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
